// File: rtl/cpu_oci_dct_pkg.sv
// cpu_oci_dct_pkg: shared sizes and FSM state type for the OCI DCT sequencer
package cpu_oci_dct_pkg;
  localparam int CODE_W = 2;
  localparam int SLOTS = 15;
  localparam int CNT_W = 4;
  localparam int BUF_W = CODE_W * SLOTS;
  localparam int OUT_W = CNT_W + BUF_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);
  typedef enum logic [1:0] {FILL, HOLD, DRAIN, DONE} state_e;
endpackage

// File: rtl/cpu_oci_dct_rr_arb.sv
// cpu_oci_dct_rr_arb: two-way round-robin arbiter; pointer toggles only on an accept
module cpu_oci_dct_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic       grant_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    grant_o = (valid_i == 2'b01) ? 1'b0 : (valid_i == 2'b10) ? 1'b1 : ptr_q;
    ptr_d = accept_i ? ~ptr_q : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cpu_oci_dct_sequencer.sv
// cpu_oci_dct_sequencer: packs arbitrated trace codes into DCT words for trace RAM.
// Defining DCT_WORD_COUNT_EN adds a saturating word_count of output handshakes.
module cpu_oci_dct_sequencer
  import cpu_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              src0_valid,
  input  logic [CODE_W-1:0] src0_code,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [CODE_W-1:0] src1_code,
  output logic              src1_ready,
  input  logic              flush_req,
  input  logic              test_ending,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_has_ended
`ifdef DCT_WORD_COUNT_EN
  ,
  output logic [15:0]       word_count
`endif
);
  state_e state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] slot_q, slot_d;
  logic flush_q, flush_d, slot_v_q, slot_v_d;
  logic grant, accept, full, slot_free, xfer;
  logic [CODE_W-1:0] code;
  cpu_oci_dct_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i ({src1_valid, src0_valid}),
    .accept_i(accept),
    .grant_o (grant)
  );
  // A transfer and an accept may share an edge: the new code lands in the emptied buffer.
  always_comb begin
    full = cnt_q == FULL_CNT;
    slot_free = !slot_v_q || out_ready;
    code = grant ? src1_code : src0_code;
    src0_ready = reset_n && state_q == FILL && !full && !grant;
    src1_ready = reset_n && state_q == FILL && !full && grant;
    accept = grant ? src1_valid && src1_ready : src0_valid && src0_ready;
    xfer = slot_free && cnt_q != '0 && (full || flush_q || state_q == DRAIN);
    buf_d = xfer ? '0 : buf_q;
    cnt_d = xfer ? '0 : cnt_q;
    if (accept) begin
      buf_d[CODE_W*cnt_d +: CODE_W] = code;
      cnt_d = cnt_d + 1'b1;
    end
    flush_d = flush_req || (flush_q && !xfer && (cnt_q != '0 || accept));
    slot_v_d = xfer || (slot_v_q && !out_ready);
    slot_d = xfer ? {cnt_q, buf_q} : slot_q;
    state_d = state_q;
    if ((state_q == FILL || state_q == HOLD) && test_ending) state_d = DRAIN;
    else if (state_q == FILL && full && !slot_free) state_d = HOLD;
    else if (state_q == HOLD && xfer) state_d = FILL;
    else if (state_q == DRAIN && cnt_q == '0 && !slot_v_q) state_d = DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FILL;
      buf_q <= '0;
      cnt_q <= '0;
      flush_q <= 1'b0;
      slot_v_q <= 1'b0;
      slot_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      flush_q <= flush_d;
      slot_v_q <= slot_v_d;
      slot_q <= slot_d;
    end
  end
  assign out_valid = slot_v_q;
  assign out_data = slot_q;
  assign dct_buffer = buf_q;
  assign dct_count = cnt_q;
  assign test_has_ended = state_q == DONE;
`ifdef DCT_WORD_COUNT_EN
  logic [15:0] wc_q;
  always_ff @(posedge clk) begin
    if (!reset_n) wc_q <= '0;
    else if (slot_v_q && out_ready && wc_q != 16'hFFFF) wc_q <= wc_q + 1'b1;
  end
  assign word_count = wc_q;
`endif
endmodule
